pac_sprite_renderer: RTL and testbench
======================================

Name: pac_sprite_renderer

Overview:
Per-pixel driver for the Pacman sprite ROM. Each cycle it takes the VGA scan position and works out whether that pixel falls inside Pacman's 16x16 box. It then drives the ROM's row, column and frame-select inputs, registers the returned 12-bit colour, and presents a pixel colour with a hit flag to the video mixer. It also owns the mouth animation sequencing and the facing-direction transform, and latches position and direction once per video frame so the sprite never tears mid-frame.

Parameters:
ANIM_DIV, 4, frame ticks per animation step; legal range 1..15.
SCREEN_W, 640, active width; documentation only, no logic depends on it.

Ports:
CLK  in  1  pixel clock
RESET_N  in  1  asynchronous active-low reset
PIXEL_X  in  10  current scan column
PIXEL_Y  in  10  current scan row
VIDEO_ON  in  1  high during active video
FRAME_TICK  in  1  one-cycle pulse, once per frame, during vertical blank
PAC_X  in  10  sprite top-left column; sampled on FRAME_TICK
PAC_Y  in  10  sprite top-left row; sampled on FRAME_TICK
DIR  in  2  facing: 0 right, 1 left, 2 up, 3 down; sampled on FRAME_TICK
MOVING  in  1  animate when high; sampled on FRAME_TICK
X_INDEX  out  4  sprite ROM first (row) index
Y_INDEX  out  4  sprite ROM second (column) index
FRAME_SELECT  out  3  sprite ROM frame, values 0..3
ROM_RGB  in  12  combinational ROM data for X_INDEX/Y_INDEX/FRAME_SELECT
PIX_RGB  out  12  sprite colour, 0 when not hit
PIX_HIT  out  1  pixel belongs to the sprite and is non-transparent
PIX_VALID  out  1  VIDEO_ON delayed to align with PIX_RGB

Behaviour:
- Reset (async, RESET_N low) clears:
  - all outputs to 0;
  - latched position to (0,0), latched direction to right (0), latched moving to 0;
  - animation phase and divider counter to 0.
- Frame latch: on the cycle FRAME_TICK=1, register PAC_X, PAC_Y, DIR and MOVING. Between ticks these inputs are ignored.
- Animation, updated only on FRAME_TICK cycles:
  - If MOVING=0 at the tick: phase <= 0 and divider <= 0.
  - Otherwise the divider increments. When it equals ANIM_DIV-1 it wraps to 0 and phase <= (phase+1) mod 4.
  - ANIM_DIV=1 advances phase on every tick.
- FRAME_SELECT is a registered copy of phase. It changes only in the cycle after FRAME_TICK, giving the sequence 0,1,2,3,0,... (the ROM maps 3 to its half-open frame).
- Stage 1 (registered, 1 cycle after PIXEL_X/PIXEL_Y):
  - Compare in 11 bits with no wraparound: hit_box = VIDEO_ON & (PIXEL_X >= px) & (PIXEL_X < px+16) & (PIXEL_Y >= py) & (PIXEL_Y < py+16).
  - dx = PIXEL_X-px and dy = PIXEL_Y-py, each truncated to 4 bits.
  - Indices by direction:
    - right: X_INDEX=dy, Y_INDEX=dx
    - left: X_INDEX=dy, Y_INDEX=15-dx
    - down: X_INDEX=dx, Y_INDEX=dy
    - up: X_INDEX=dx, Y_INDEX=15-dy
  - When hit_box=0, X_INDEX and Y_INDEX are driven to 0.
- Stage 2 (registered, 2 cycles after pixel input):
  - PIX_HIT = hit_box_q & (ROM_RGB != 12'h000); colour 000 is the transparent key.
  - PIX_RGB = PIX_HIT ? ROM_RGB : 0.
  - PIX_VALID = VIDEO_ON delayed by 2 cycles.
- Total latency from pixel inputs to PIX_* is 2 cycles. The mixer delays its own pipeline to match.
- Boundary conditions:
  - Sprite partly off the right or bottom edge: px+16 may exceed 639; pixels beyond the edge are never scanned, with no wrap to column 0.
  - px=0 or py=0 is valid.
  - A FRAME_TICK coinciding with an in-box pixel is legal: that pixel uses the old latched values, later pixels use the new ones.
  - A mid-frame reset returns everything to the reset state immediately. The next FRAME_TICK re-latches position.

Optional Feature:
PAC_ROTATE_EN. When defined, the DIR transform above is implemented. When undefined, DIR is neither sampled nor used; indices are always X_INDEX=dy, Y_INDEX=dx (facing right), and the direction register is omitted.

Test Plan:
- Reset then release, PIXEL sweep with VIDEO_ON=1 -> PIX_RGB=0, PIX_HIT=0, FRAME_SELECT=0, PIX_VALID follows VIDEO_ON with 2-cycle delay.
- FRAME_TICK with PAC_X=100, PAC_Y=50, DIR=0; pixel (107,57) -> X_INDEX=7, Y_INDEX=7 after 1 cycle; PIX_HIT=1, PIX_RGB=FF0 after 2 cycles; pixels (99,57) and (116,57) -> PIX_HIT=0.
- MOVING=1, ANIM_DIV=4, 16 FRAME_TICKs -> FRAME_SELECT steps 0,1,2,3,0 every 4 ticks; MOVING=0 at the next tick -> FRAME_SELECT=0.
- DIR=1 (left), pixel offset dx=2, dy=5 -> X_INDEX=5, Y_INDEX=13; DIR=2 (up) -> X_INDEX=2, Y_INDEX=10; with PAC_ROTATE_EN undefined -> X_INDEX=5, Y_INDEX=2.
- PAC_X changed to 200 without FRAME_TICK -> hits remain at column 100 until the next tick; ROM returns 000 at an in-box pixel -> PIX_HIT=0, PIX_RGB=0.
- PAC_X=630 -> pixel 639 in-box hit, no hit at columns 0..5; RESET_N low mid-line -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pac_sprite_renderer.sv
// Pacman sprite pixel driver: box test, ROM index generation, mouth animation, 2-cycle pixel pipeline.
// Optional facing-direction transform is enabled by defining PAC_ROTATE_EN.
module pac_sprite_renderer #(
    parameter int ANIM_DIV = 4,
    parameter int SCREEN_W = 640
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [9:0]  i_pixel_x,
    input  logic [9:0]  i_pixel_y,
    input  logic        i_video_on,
    input  logic        i_frame_tick,
    input  logic [9:0]  i_pac_x,
    input  logic [9:0]  i_pac_y,
    input  logic [1:0]  i_dir,
    input  logic        i_moving,
    output logic [3:0]  o_x_index,
    output logic [3:0]  o_y_index,
    output logic [2:0]  o_frame_select,
    input  logic [11:0] i_rom_rgb,
    output logic [11:0] o_pix_rgb,
    output logic        o_pix_hit,
    output logic        o_pix_valid
);

    localparam logic [3:0] DIV_LAST = 4'(ANIM_DIV - 1);

    generate
        if (ANIM_DIV < 1 || ANIM_DIV > 15 || SCREEN_W < 16) begin : g_param_check
            $error("pac_sprite_renderer: ANIM_DIV must be 1..15 and SCREEN_W at least 16");
        end
    endgenerate

    logic [9:0]  r_px;
    logic [9:0]  r_py;
    logic        r_moving;
    logic [1:0]  r_phase;
    logic [3:0]  r_div;
    logic        r_hit_box;
    logic        r_video_d1;
    logic        w_moving;
    logic        w_hit_box;
    logic        w_pix_hit;
    logic [10:0] w_x11;
    logic [10:0] w_y11;
    logic [10:0] w_px11;
    logic [10:0] w_py11;
    logic [3:0]  w_dx;
    logic [3:0]  w_dy;
    logic [3:0]  w_x_raw;
    logic [3:0]  w_y_raw;
    logic [3:0]  w_x_idx;
    logic [3:0]  w_y_idx;

`ifdef PAC_ROTATE_EN
    logic [1:0]  r_dir;

    // Per-frame snapshot of sprite state, including facing direction
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_px     <= 10'd0;
            r_py     <= 10'd0;
            r_dir    <= 2'd0;
            r_moving <= 1'b0;
        end else if (i_frame_tick) begin
            r_px     <= i_pac_x;
            r_py     <= i_pac_y;
            r_dir    <= i_dir;
            r_moving <= i_moving;
        end
    end
`else
    logic w_unused_dir;
    assign w_unused_dir = ^i_dir;

    // Per-frame snapshot of sprite state; direction is not tracked in this build
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_px     <= 10'd0;
            r_py     <= 10'd0;
            r_moving <= 1'b0;
        end else if (i_frame_tick) begin
            r_px     <= i_pac_x;
            r_py     <= i_pac_y;
            r_moving <= i_moving;
        end
    end
`endif

    // On a tick the incoming MOVING governs this tick's step, not last frame's snapshot
    assign w_moving = i_frame_tick ? i_moving : r_moving;

    // Mouth animation: divider counts frame ticks, phase cycles 0..3
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_phase <= 2'd0;
            r_div   <= 4'd0;
        end else if (i_frame_tick) begin
            if (!w_moving) begin
                r_phase <= 2'd0;
                r_div   <= 4'd0;
            end else if (r_div == DIV_LAST) begin
                r_div   <= 4'd0;
                r_phase <= r_phase + 2'd1;
            end else begin
                r_div   <= r_div + 4'd1;
            end
        end
    end

    // Widened compares so a sprite hanging past the right/bottom edge never wraps
    assign w_x11     = {1'b0, i_pixel_x};
    assign w_y11     = {1'b0, i_pixel_y};
    assign w_px11    = {1'b0, r_px};
    assign w_py11    = {1'b0, r_py};
    assign w_hit_box = i_video_on
                     & (w_x11 >= w_px11) & (w_x11 < (w_px11 + 11'd16))
                     & (w_y11 >= w_py11) & (w_y11 < (w_py11 + 11'd16));
    assign w_dx      = i_pixel_x[3:0] - r_px[3:0];
    assign w_dy      = i_pixel_y[3:0] - r_py[3:0];

    // ROM index selection by facing direction, zeroed outside the box
    always_comb begin
        w_x_raw = w_dy;
        w_y_raw = w_dx;
`ifdef PAC_ROTATE_EN
        case (r_dir)
            2'd0: begin w_x_raw = w_dy; w_y_raw = w_dx;          end
            2'd1: begin w_x_raw = w_dy; w_y_raw = 4'd15 - w_dx;  end
            2'd2: begin w_x_raw = w_dx; w_y_raw = 4'd15 - w_dy;  end
            2'd3: begin w_x_raw = w_dx; w_y_raw = w_dy;          end
            default: begin w_x_raw = w_dy; w_y_raw = w_dx;       end
        endcase
`endif
        if (w_hit_box) begin
            w_x_idx = w_x_raw;
            w_y_idx = w_y_raw;
        end else begin
            w_x_idx = 4'd0;
            w_y_idx = 4'd0;
        end
    end

    // Stage 1: ROM address, box flag and video-on alignment
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_x_index      <= 4'd0;
            o_y_index      <= 4'd0;
            r_hit_box      <= 1'b0;
            r_video_d1     <= 1'b0;
            o_frame_select <= 3'd0;
        end else begin
            o_x_index      <= w_x_idx;
            o_y_index      <= w_y_idx;
            r_hit_box      <= w_hit_box;
            r_video_d1     <= i_video_on;
            o_frame_select <= {1'b0, r_phase};
        end
    end

    assign w_pix_hit = r_hit_box & (i_rom_rgb != 12'h000);

    // Stage 2: colour 000 is the transparent key
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pix_hit   <= 1'b0;
            o_pix_rgb   <= 12'h000;
            o_pix_valid <= 1'b0;
        end else begin
            o_pix_hit   <= w_pix_hit;
            o_pix_rgb   <= w_pix_hit ? i_rom_rgb : 12'h000;
            o_pix_valid <= r_video_d1;
        end
    end

endmodule

// File: tb/tb_pac_sprite_renderer.sv
// Directed self-checking bench for pac_sprite_renderer (default ANIM_DIV=4, constant-colour ROM stand-in).
module tb_pac_sprite_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pixel_x = 10'd0;
    logic [9:0]  pixel_y = 10'd0;
    logic        video_on = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  pac_x = 10'd0;
    logic [9:0]  pac_y = 10'd0;
    logic [1:0]  dir = 2'd0;
    logic        moving = 1'b0;
    logic        rom_zero = 1'b0;
    logic [3:0]  x_index;
    logic [3:0]  y_index;
    logic [2:0]  frame_select;
    logic [11:0] rom_rgb;
    logic [11:0] pix_rgb;
    logic        pix_hit;
    logic        pix_valid;

    int n_cmp = 0;
    int n_err = 0;

    assign rom_rgb = rom_zero ? 12'h000 : 12'hFF0;

    always #5 clk = ~clk;

    pac_sprite_renderer dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_pixel_x      (pixel_x),
        .i_pixel_y      (pixel_y),
        .i_video_on     (video_on),
        .i_frame_tick   (frame_tick),
        .i_pac_x        (pac_x),
        .i_pac_y        (pac_y),
        .i_dir          (dir),
        .i_moving       (moving),
        .o_x_index      (x_index),
        .o_y_index      (y_index),
        .o_frame_select (frame_select),
        .i_rom_rgb      (rom_rgb),
        .o_pix_rgb      (pix_rgb),
        .o_pix_hit      (pix_hit),
        .o_pix_valid    (pix_valid)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic ft(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d, input logic m);
        pac_x = x; pac_y = y; dir = d; moving = m;
        frame_tick = 1'b1;
        tick_clk();
        frame_tick = 1'b0;
        tick_clk();
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y);
        pixel_x = x; pixel_y = y; video_on = 1'b1;
        tick_clk();
    endtask

    logic [5:0] vpat = 6'b101101;
    logic [1:0] exp_fs;

    initial begin
        // reset state
        tick_clk(); tick_clk();
        chk("rst_hit", pix_hit, 1'b0);
        chk("rst_rgb", pix_rgb, 12'h000);
        chk("rst_valid", pix_valid, 1'b0);
        chk("rst_fs", frame_select, 3'd0);
        rst_n = 1'b1;
        tick_clk(); tick_clk();

        // sweep outside the origin box; PIX_VALID lags VIDEO_ON by two cycles
        for (int i = 0; i < 6; i++) begin
            pixel_x = 10'(20 + i); pixel_y = 10'd100; video_on = vpat[i];
            tick_clk();
            chk("sweep_valid", pix_valid, (i >= 1) ? vpat[i-1] : 1'b0);
            chk("sweep_hit", pix_hit, 1'b0);
            chk("sweep_rgb", pix_rgb, 12'h000);
        end
        chk("sweep_fs", frame_select, 3'd0);

        // basic hit at (100,50) facing right
        ft(10'd100, 10'd50, 2'd0, 1'b0);
        drive(10'd107, 10'd57);
        chk("c_xi", x_index, 4'd7);
        chk("c_yi", y_index, 4'd7);
        tick_clk();
        chk("c_hit", pix_hit, 1'b1);
        chk("c_rgb", pix_rgb, 12'hFF0);
        drive(10'd103, 10'd59);
        chk("asym_xi", x_index, 4'd9);
        chk("asym_yi", y_index, 4'd3);
        drive(10'd99, 10'd57);
        chk("left_xi", x_index, 4'd0);
        tick_clk();
        chk("left_hit", pix_hit, 1'b0);
        chk("left_rgb", pix_rgb, 12'h000);
        drive(10'd116, 10'd57);
        tick_clk();
        chk("right_hit", pix_hit, 1'b0);
        drive(10'd115, 10'd65);
        chk("corner_xi", x_index, 4'd15);
        chk("corner_yi", y_index, 4'd15);
        tick_clk();
        chk("corner_hit", pix_hit, 1'b1);
        drive(10'd100, 10'd66);
        tick_clk();
        chk("below_hit", pix_hit, 1'b0);

        // animation: phase advances every 4 moving ticks
        for (int n = 1; n <= 13; n++) begin
            ft(10'd100, 10'd50, 2'd0, 1'b1);
            exp_fs = 2'((n / 4) % 4);
            chk("anim_fs", frame_select, {1'b0, exp_fs});
        end
        ft(10'd100, 10'd50, 2'd0, 1'b0);
        chk("stop_fs", frame_select, 3'd0);
        for (int n = 1; n <= 3; n++) begin
            ft(10'd100, 10'd50, 2'd0, 1'b1);
            chk("restart_fs", frame_select, 3'd0);
        end
        ft(10'd100, 10'd50, 2'd0, 1'b1);
        chk("restart_step", frame_select, 3'd1);
        ft(10'd100, 10'd50, 2'd0, 1'b0);

        // direction transforms at dx=2, dy=5
`ifdef PAC_ROTATE_EN
        ft(10'd100, 10'd50, 2'd1, 1'b0);
        drive(10'd102, 10'd55);
        chk("dir_l_xi", x_index, 4'd5);
        chk("dir_l_yi", y_index, 4'd13);
        ft(10'd100, 10'd50, 2'd2, 1'b0);
        drive(10'd102, 10'd55);
        chk("dir_u_xi", x_index, 4'd2);
        chk("dir_u_yi", y_index, 4'd10);
        ft(10'd100, 10'd50, 2'd3, 1'b0);
        drive(10'd102, 10'd55);
        chk("dir_d_xi", x_index, 4'd2);
        chk("dir_d_yi", y_index, 4'd5);
`else
        ft(10'd100, 10'd50, 2'd1, 1'b0);
        drive(10'd102, 10'd55);
        chk("norot_xi", x_index, 4'd5);
        chk("norot_yi", y_index, 4'd2);
`endif
        ft(10'd100, 10'd50, 2'd0, 1'b0);
        drive(10'd102, 10'd55);
        chk("dir_r_xi", x_index, 4'd5);
        chk("dir_r_yi", y_index, 4'd2);

        // PAC_X change without a tick is ignored
        pac_x = 10'd200;
        drive(10'd105, 10'd55);
        tick_clk();
        chk("hold_old_hit", pix_hit, 1'b1);
        drive(10'd205, 10'd55);
        tick_clk();
        chk("hold_new_hit", pix_hit, 1'b0);

        // transparent key
        rom_zero = 1'b1;
        drive(10'd105, 10'd55);
        chk("transp_xi", x_index, 4'd5);
        tick_clk();
        chk("transp_hit", pix_hit, 1'b0);
        chk("transp_rgb", pix_rgb, 12'h000);
        rom_zero = 1'b0;

        // move to 200, then a tick that coincides with an in-box pixel
        ft(10'd200, 10'd50, 2'd0, 1'b0);
        pac_x = 10'd300; frame_tick = 1'b1;
        drive(10'd207, 10'd55);
        frame_tick = 1'b0;
        chk("coinc_xi", x_index, 4'd5);
        chk("coinc_yi", y_index, 4'd7);
        tick_clk();
        chk("coinc_old_hit", pix_hit, 1'b1);
        tick_clk();
        chk("coinc_new_hit", pix_hit, 1'b0);

        // sprite hanging off the right edge
        for (int n = 0; n < 4; n++) ft(10'd630, 10'd50, 2'd0, 1'b1);
        chk("edge_fs", frame_select, 3'd1);
        for (int x = 0; x < 6; x++) begin
            drive(10'(x), 10'd55);
            tick_clk();
            chk("edge_wrap_hit", pix_hit, 1'b0);
        end
        drive(10'd639, 10'd55);
        chk("edge_xi", x_index, 4'd5);
        chk("edge_yi", y_index, 4'd9);
        tick_clk();
        chk("edge_hit", pix_hit, 1'b1);
        chk("edge_valid", pix_valid, 1'b1);

        // asynchronous reset mid-line
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hit", pix_hit, 1'b0);
        chk("arst_rgb", pix_rgb, 12'h000);
        chk("arst_valid", pix_valid, 1'b0);
        chk("arst_xi", x_index, 4'd0);
        chk("arst_yi", y_index, 4'd0);
        chk("arst_fs", frame_select, 3'd0);
        tick_clk(); tick_clk();
        rst_n = 1'b1;
        drive(10'd3, 10'd4);
        chk("post_rst_xi", x_index, 4'd4);
        chk("post_rst_yi", y_index, 4'd3);
        tick_clk();
        chk("post_rst_hit", pix_hit, 1'b1);
        ft(10'd100, 10'd50, 2'd0, 1'b0);
        drive(10'd3, 10'd4);
        tick_clk();
        chk("relatch_hit", pix_hit, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
